note_player: RTL

Upstream driver for `sine_reader`; one instance per voice.
- Accepts a note number and a duration from the song sequencer.
- Converts the note to a 20-bit phase step through a frequency ROM and counts the duration in beats.
- Serves codec sample requests by running the `generate_next`/`sample_ready` handshake on `sine_reader`, emitting silence while paused or resting.
- Sits between the song reader (upstream) and `sine_reader` plus the codec sample path (downstream).

---
 rtl/music_pkg.sv | 33 +++
 rtl/frequency_rom.sv | 19 +
 rtl/note_player.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the note_player voice.
// FREQ_ROM maps piano key numbers (49 = A4 = 440 Hz) to 20-bit phase steps
// for a 1024-entry sine table with 10 fractional bits at 48 kHz.
package music_pkg;

  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int STEP_W   = 20;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    DONE
  } note_state_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } sample_state_t;

  localparam logic [STEP_W-1:0] FREQ_ROM [64] = '{
    20'd0,     20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,   20'd850,
    20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,  20'd1201,  20'd1273,  20'd1349,
    20'd1429,  20'd1514,  20'd1604,  20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,
    20'd2268,  20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,  20'd3398,
    20'd3600,  20'd3814,  20'd4041,  20'd4282,  20'd4536,  20'd4806,  20'd5092,  20'd5394,
    20'd5715,  20'd6055,  20'd6415,  20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,
    20'd9072,  20'd9612,  20'd10183, 20'd10789, 20'd11430, 20'd12110, 20'd12830, 20'd13593,
    20'd14402, 20'd15258, 20'd16165, 20'd17126, 20'd18145, 20'd19224, 20'd20367, 20'd21578
  };

endpackage

// File: rtl/frequency_rom.sv
// Registered note -> phase step lookup, one cycle of latency.
// When en is low the step is forced to 0 so the voice is silent in IDLE.
module frequency_rom
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step_size
);

  // Table lookup registered on every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_size <= '0;
    else        step_size <= en ? FREQ_ROM[note] : '0;
  end

endmodule

// File: rtl/note_player.sv
// One voice: note/duration sequencing, phase step generation and codec
// sample serving through the sine_reader handshake.
// Optional build macro NOTE_PLAYER_ENVELOPE_EN halves voiced samples on the
// final beat of a note as a simple release.
//
// Note FSM
//   state   | meaning
//   IDLE    | no note active, step_size forced to 0
//   PLAYING | counting beats of the latched duration
//   DONE    | note finished, done_with_note high for this cycle
// Sample FSM
//   state   | meaning
//   S_IDLE  | waiting for a codec request
//   S_WAIT  | sine_reader asked for a sample, waiting for its ready
module note_player
  import music_pkg::*;
#(
  parameter int NOTE_W = music_pkg::NOTE_W,
  parameter int DUR_W  = music_pkg::DUR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                load_new_note,
  input  logic [NOTE_W-1:0]   note_to_load,
  input  logic [DUR_W-1:0]    duration_to_load,
  input  logic                beat,
  input  logic                generate_next_sample,
  input  logic [SAMPLE_W-1:0] sine_sample,
  input  logic                sine_sample_ready,
  output logic [STEP_W-1:0]   step_size,
  output logic                sine_generate_next,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready,
  output logic                done_with_note
);

  note_state_t         note_state_q, note_state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;

  sample_state_t       s_state_q, s_state_d;
  logic                gen_d, rdy_d;
  logic [SAMPLE_W-1:0] smp_d, voiced_sample;
  logic                voiced;

  // Note FSM state, latched note and beat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_state_q <= IDLE;
      note_q       <= '0;
      cnt_q        <= '0;
    end else begin
      note_state_q <= note_state_d;
      note_q       <= note_d;
      cnt_q        <= cnt_d;
    end
  end

  // Note FSM next state; a load overrides everything, including the final beat.
  always_comb begin
    note_state_d = note_state_q;
    note_d       = note_q;
    cnt_d        = cnt_q;
    case (note_state_q)
      PLAYING: begin
        if (beat && play_enable) begin
          if (cnt_q == DUR_W'(1)) begin
            cnt_d        = '0;
            note_state_d = DONE;
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
      end
      DONE:    note_state_d = IDLE;
      default: ;
    endcase
    if (load_new_note) begin
      note_d       = note_to_load;
      cnt_d        = duration_to_load;
      note_state_d = (duration_to_load == '0) ? DONE : PLAYING;
    end
  end

  assign done_with_note = (note_state_q == DONE);

  // The ROM is fed the next-cycle note so step_size lands one cycle after a load.
  frequency_rom u_frequency_rom (
    .clk       (clk),
    .reset     (reset),
    .en        (note_state_d != IDLE),
    .note      (note_d),
    .step_size (step_size)
  );

  assign voiced = (note_state_q == PLAYING) && play_enable && (note_q != '0);

`ifdef NOTE_PLAYER_ENVELOPE_EN
  assign voiced_sample = ((note_state_q == PLAYING) && (cnt_q == DUR_W'(1)))
                         ? SAMPLE_W'($signed(sine_sample) >>> 1)
                         : sine_sample;
`else
  assign voiced_sample = sine_sample;
`endif

  // Sample FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state_q          <= S_IDLE;
      sine_generate_next <= 1'b0;
      new_sample_ready   <= 1'b0;
      sample_out         <= '0;
    end else begin
      s_state_q          <= s_state_d;
      sine_generate_next <= gen_d;
      new_sample_ready   <= rdy_d;
      sample_out         <= smp_d;
    end
  end

  // Sample FSM next state; a pending sine sample is delivered even if the note changes.
  always_comb begin
    s_state_d = s_state_q;
    gen_d     = 1'b0;
    rdy_d     = 1'b0;
    smp_d     = sample_out;
    case (s_state_q)
      S_IDLE: begin
        if (generate_next_sample) begin
          if (voiced) begin
            gen_d     = 1'b1;
            s_state_d = S_WAIT;
          end else begin
            rdy_d = 1'b1;
            smp_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (sine_sample_ready) begin
          rdy_d     = 1'b1;
          smp_d     = voiced_sample;
          s_state_d = S_IDLE;
        end
      end
      default: s_state_d = S_IDLE;
    endcase
  end

endmodule
